zx81_tape_player: RTL and testbench

ZX81_TAPE_PLAYER -- requirements
Module: zx81_tape_player

---
 rtl/zx81_tape_player.sv | 181 ++++++++++++++++++
 tb/tb_zx81_tape_player.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zx81_tape_player.sv
// ---------------------------------------------------------------------------
// zx81_tape_player
//
// Plays a .P file byte stream as a ZX81 tape waveform on the ear input.
// Each bit is a burst of pulses followed by a silent gap. A "0" bit is
// 4 pulses and a "1" bit is 9 pulses. Bits are sent MSB first. A one-byte
// holding register lets the next byte arrive while the current one is being
// shifted out, so consecutive bytes play without any idle cycle between them.
//
// Parameters
//   PULSE_CYCLES : length of each pulse half, in buffer_clk cycles
//   GAP_CYCLES   : silence after each bit, in buffer_clk cycles
//   EAR_INVERT   : 1 inverts ear_out
//
// Ports
//   buffer_clk   : clock, rising edge
//   reset_n      : synchronous active-low reset
//   enable       : playback permitted; dropping it aborts immediately
//   byte_data    : next tape byte on offer
//   byte_valid   : byte_data holds a byte on offer
//   byte_ready   : holding register empty, so a byte can be accepted
//   ear_out      : registered tape signal (high = pulse before inversion)
//   busy         : transmitting or holding a pending byte
//   bytes_sent   : count of fully transmitted bytes (wraps)
// ---------------------------------------------------------------------------
module zx81_tape_player #(
    parameter int PULSE_CYCLES = 7500,
    parameter int GAP_CYCLES   = 65000,
    parameter bit EAR_INVERT   = 1'b0
) (
    input  logic        buffer_clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        ear_out,
    output logic        busy,
    output logic [15:0] bytes_sent
);

    // One shared phase counter is used for pulse halves and gaps, so it is
    // sized for the longer of the two.
    localparam int MAX_CYCLES = (GAP_CYCLES > PULSE_CYCLES) ? GAP_CYCLES : PULSE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    localparam logic EAR_LOW  = EAR_INVERT;
    localparam logic EAR_HIGH = ~EAR_INVERT;

    typedef enum logic [1:0] {
        IDLE,
        PULSE_HI,
        PULSE_LO,
        GAP
    } state_t;

    state_t           state;
    logic [7:0]       hold_reg;
    logic             hold_full;
    logic [7:0]       shifter;
    logic [CNT_W-1:0] cycle_cnt;
    logic [3:0]       pulse_cnt;
    logic [2:0]       bit_cnt;
    logic             accept;

    function automatic logic [3:0] pulses_for(input logic bit_value);
        return bit_value ? 4'd9 : 4'd4;
    endfunction

    assign accept     = byte_valid & ~hold_full & enable;
    assign byte_ready = ~hold_full;
    assign busy       = (state != IDLE) | hold_full;

    // Accept and load never coincide: an accept needs the holding register
    // empty, a load needs it full. Each phase lasts exactly its cycle count
    // because the counter restarts at zero on every phase entry.
    always_ff @(posedge buffer_clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            hold_reg   <= 8'h00;
            hold_full  <= 1'b0;
            shifter    <= 8'h00;
            cycle_cnt  <= '0;
            pulse_cnt  <= 4'd0;
            bit_cnt    <= 3'd0;
            ear_out    <= EAR_LOW;
            bytes_sent <= 16'h0000;
        end else if (!enable) begin
            // Abort: drop everything in flight but keep the completed count.
            state     <= IDLE;
            hold_full <= 1'b0;
            cycle_cnt <= '0;
            pulse_cnt <= 4'd0;
            bit_cnt   <= 3'd0;
            ear_out   <= EAR_LOW;
        end else begin
            if (accept) begin
                hold_reg  <= byte_data;
                hold_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    ear_out <= EAR_LOW;
                    if (hold_full) begin
                        shifter   <= hold_reg;
                        hold_full <= 1'b0;
                        pulse_cnt <= pulses_for(hold_reg[7]);
                        bit_cnt   <= 3'd0;
                        cycle_cnt <= '0;
                        ear_out   <= EAR_HIGH;
                        state     <= PULSE_HI;
                    end
                end

                PULSE_HI: begin
                    if (cycle_cnt == PULSE_LAST) begin
                        cycle_cnt <= '0;
                        ear_out   <= EAR_LOW;
                        state     <= PULSE_LO;
                    end else begin
                        cycle_cnt <= cycle_cnt + CNT_W'(1);
                    end
                end

                PULSE_LO: begin
                    if (cycle_cnt == PULSE_LAST) begin
                        cycle_cnt <= '0;
                        pulse_cnt <= pulse_cnt - 4'd1;
                        if (pulse_cnt != 4'd1) begin
                            ear_out <= EAR_HIGH;
                            state   <= PULSE_HI;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + CNT_W'(1);
                    end
                end

                GAP: begin
                    if (cycle_cnt == GAP_LAST) begin
                        cycle_cnt <= '0;
                        if (bit_cnt != 3'd7) begin
                            // shifter[6] becomes the new MSB after this shift
                            bit_cnt   <= bit_cnt + 3'd1;
                            shifter   <= {shifter[6:0], 1'b0};
                            pulse_cnt <= pulses_for(shifter[6]);
                            ear_out   <= EAR_HIGH;
                            state     <= PULSE_HI;
                        end else begin
                            bytes_sent <= bytes_sent + 16'd1;
                            if (hold_full) begin
                                // Chain straight into the next byte.
                                shifter   <= hold_reg;
                                hold_full <= 1'b0;
                                pulse_cnt <= pulses_for(hold_reg[7]);
                                bit_cnt   <= 3'd0;
                                ear_out   <= EAR_HIGH;
                                state     <= PULSE_HI;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end else begin
                        cycle_cnt <= cycle_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    ear_out <= EAR_LOW;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zx81_tape_player.sv
// ---------------------------------------------------------------------------
// tb_zx81_tape_player
//
// Bench for zx81_tape_player with short timing (PULSE=4, GAP=10). The
// expected ear waveform is built from the tape encoding rules: per bit,
// 4 or 9 pulses of 4 high + 4 low cycles, then 10 silent cycles.
// ---------------------------------------------------------------------------
module tb_zx81_tape_player;

    localparam int P = 4;
    localparam int G = 10;

    logic        buffer_clk = 1'b0;
    logic        reset_n    = 1'b0;
    logic        enable     = 1'b0;
    logic [7:0]  byte_data  = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        ear_out;
    logic        busy;
    logic [15:0] bytes_sent;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [15:0] exp_sent     = 16'h0000;
    bit          exp_q[$];
    bit          got_q[$];

    zx81_tape_player #(
        .PULSE_CYCLES (P),
        .GAP_CYCLES   (G),
        .EAR_INVERT   (1'b0)
    ) dut (
        .buffer_clk (buffer_clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .ear_out    (ear_out),
        .busy       (busy),
        .bytes_sent (bytes_sent)
    );

    always #5 buffer_clk = ~buffer_clk;

    // Reference: append the full waveform of one byte to exp_q.
    function automatic void model_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            int n;
            n = b[i] ? 9 : 4;
            for (int p = 0; p < n; p++) begin
                for (int c = 0; c < P; c++) exp_q.push_back(1'b1);
                for (int c = 0; c < P; c++) exp_q.push_back(1'b0);
            end
            for (int c = 0; c < G; c++) exp_q.push_back(1'b0);
        end
    endfunction

    function automatic int bit_len(input logic b);
        return (b ? 9 : 4) * 2 * P + G;
    endfunction

    // Offers each byte in turn, holding valid high until it is taken.
    task automatic offer_bytes(input logic [7:0] bytes[$], output bit ok);
        ok = 1'b1;
        foreach (bytes[k]) begin
            int guard;
            byte_data  = bytes[k];
            byte_valid = 1'b1;
            guard      = 0;
            while (byte_ready !== 1'b1 && guard < 2000) begin
                @(negedge buffer_clk);
                guard++;
            end
            if (guard >= 2000) ok = 1'b0;
            @(negedge buffer_clk);
        end
        byte_valid = 1'b0;
    endtask

    // Records ear_out from the first high cycle until busy falls.
    task automatic capture_wave(input int max_cycles, output bit timed_out);
        bit started;
        started   = 1'b0;
        timed_out = 1'b1;
        got_q.delete();
        for (int c = 0; c < max_cycles; c++) begin
            if (started && busy !== 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            if (ear_out === 1'b1) started = 1'b1;
            if (started) got_q.push_back(ear_out);
            @(negedge buffer_clk);
        end
    endtask

    task automatic wait_for_pulse(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (ear_out === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge buffer_clk);
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        enable     = 1'b1;
        byte_valid = 1'b0;
        repeat (3) @(negedge buffer_clk);
        tests_run++;
        if (ear_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ear: got %b expected 0", ear_out);
        end
        tests_run++;
        if (byte_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_ready: got %b expected 1", byte_ready);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        tests_run++;
        if (bytes_sent !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_count: got %h expected 0000", bytes_sent);
        end
        // Accept on the very first edge with reset released.
        reset_n    = 1'b1;
        byte_data  = 8'hC3;
        byte_valid = 1'b1;
        @(negedge buffer_clk);
        byte_valid = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || byte_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL first_accept: got busy=%b ready=%b expected busy=1 ready=0", busy, byte_ready);
        end
        enable = 1'b0;
        @(negedge buffer_clk);
        enable = 1'b1;
        @(negedge buffer_clk);
    endtask

    task automatic test_single_bytes();
        logic [7:0] list[$];
        list = '{8'h00, 8'hFF, 8'h80};
        repeat (3) list.push_back(8'($urandom_range(0, 255)));
        foreach (list[k]) begin
            logic [7:0] one[$];
            bit ok, tmo;
            int bad;
            one = '{list[k]};
            exp_q.delete();
            model_byte(list[k]);
            fork
                offer_bytes(one, ok);
                capture_wave(2000, tmo);
            join
            tests_run++;
            if (!ok || tmo) begin
                tests_failed++;
                $display("[TB] FAIL single_timeout_%h: got ok=%b timeout=%b expected ok=1 timeout=0", list[k], ok, tmo);
            end
            bad = -1;
            if (got_q.size() != exp_q.size()) bad = 0;
            else foreach (exp_q[i]) if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
            tests_run++;
            if (bad >= 0) begin
                tests_failed++;
                $display("[TB] FAIL wave_%h: got %0d cycles (first diff %0d) expected %0d cycles", list[k], got_q.size(), bad, exp_q.size());
            end
            if (list[k] == 8'h00 || list[k] == 8'hFF) begin
                tests_run++;
                if (got_q.size() != ((list[k] == 8'h00) ? 336 : 656)) begin
                    tests_failed++;
                    $display("[TB] FAIL length_%h: got %0d expected %0d", list[k], got_q.size(), (list[k] == 8'h00) ? 336 : 656);
                end
            end
            exp_sent = exp_sent + 16'd1;
            tests_run++;
            if (bytes_sent !== exp_sent) begin
                tests_failed++;
                $display("[TB] FAIL count_%h: got %0d expected %0d", list[k], bytes_sent, exp_sent);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pairs[$];
        pairs = '{8'h55, 8'hAA, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
        for (int k = 0; k < 4; k += 2) begin
            logic [7:0] two[$];
            bit ok, tmo;
            int bad;
            two = '{pairs[k], pairs[k+1]};
            exp_q.delete();
            model_byte(pairs[k]);
            model_byte(pairs[k+1]);
            fork
                offer_bytes(two, ok);
                capture_wave(4000, tmo);
            join
            tests_run++;
            if (!ok || tmo) begin
                tests_failed++;
                $display("[TB] FAIL b2b_timeout_%h%h: got ok=%b timeout=%b expected ok=1 timeout=0", pairs[k], pairs[k+1], ok, tmo);
            end
            bad = -1;
            if (got_q.size() != exp_q.size()) bad = 0;
            else foreach (exp_q[i]) if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
            tests_run++;
            if (bad >= 0) begin
                tests_failed++;
                $display("[TB] FAIL b2b_wave_%h%h: got %0d cycles (first diff %0d) expected %0d cycles", pairs[k], pairs[k+1], got_q.size(), bad, exp_q.size());
            end
            exp_sent = exp_sent + 16'd2;
            tests_run++;
            if (bytes_sent !== exp_sent) begin
                tests_failed++;
                $display("[TB] FAIL b2b_count: got %0d expected %0d", bytes_sent, exp_sent);
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] b;
        logic [7:0] one[$];
        bit ok;
        int target;
        bit stray;
        b      = 8'($urandom_range(0, 255));
        one    = '{b};
        // Third pulse of bit 5: after bits 7 and 6 and two full pulses.
        target = bit_len(b[7]) + bit_len(b[6]) + 2 * 2 * P + 1;
        offer_bytes(one, ok);
        wait_for_pulse(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL abort_start: got no pulse expected pulse");
        end
        byte_data  = 8'($urandom_range(0, 255));
        byte_valid = 1'b1;
        @(negedge buffer_clk);
        byte_valid = 1'b0;
        repeat (target - 1) @(negedge buffer_clk);
        tests_run++;
        if (ear_out !== 1'b1 || byte_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_pre: got ear=%b ready=%b expected ear=1 ready=0", ear_out, byte_ready);
        end
        enable = 1'b0;
        @(negedge buffer_clk);
        tests_run++;
        if (ear_out !== 1'b0 || byte_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_state: got ear=%b ready=%b busy=%b expected 0 1 0", ear_out, byte_ready, busy);
        end
        tests_run++;
        if (bytes_sent !== exp_sent) begin
            tests_failed++;
            $display("[TB] FAIL abort_count: got %0d expected %0d", bytes_sent, exp_sent);
        end
        enable = 1'b1;
        stray  = 1'b0;
        repeat (20) begin
            @(negedge buffer_clk);
            if (busy !== 1'b0 || ear_out !== 1'b0) stray = 1'b1;
        end
        tests_run++;
        if (stray) begin
            tests_failed++;
            $display("[TB] FAIL abort_resume: got activity expected silence");
        end
    endtask

    task automatic test_reset_mid_gap();
        logic [7:0] b;
        logic [7:0] one[$];
        bit ok;
        bit stray;
        b   = 8'($urandom_range(0, 255));
        one = '{b};
        offer_bytes(one, ok);
        wait_for_pulse(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL rst_start: got no pulse expected pulse");
        end
        byte_data  = 8'($urandom_range(0, 255));
        byte_valid = 1'b1;
        @(negedge buffer_clk);
        byte_valid = 1'b0;
        repeat ((b[7] ? 9 : 4) * 2 * P + 5 - 1) @(negedge buffer_clk);
        tests_run++;
        if (ear_out !== 1'b0 || byte_ready !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL rst_pre: got ear=%b ready=%b busy=%b expected 0 0 1", ear_out, byte_ready, busy);
        end
        reset_n = 1'b0;
        @(negedge buffer_clk);
        reset_n  = 1'b1;
        exp_sent = 16'h0000;
        tests_run++;
        if (ear_out !== 1'b0 || byte_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rst_state: got ear=%b ready=%b busy=%b expected 0 1 0", ear_out, byte_ready, busy);
        end
        tests_run++;
        if (bytes_sent !== exp_sent) begin
            tests_failed++;
            $display("[TB] FAIL rst_count: got %0d expected %0d", bytes_sent, exp_sent);
        end
        stray = 1'b0;
        repeat (30) begin
            @(negedge buffer_clk);
            if (busy !== 1'b0 || ear_out !== 1'b0) stray = 1'b1;
        end
        tests_run++;
        if (stray) begin
            tests_failed++;
            $display("[TB] FAIL rst_discard: got activity expected silence");
        end
    endtask

    initial begin
        @(negedge buffer_clk);
        test_reset();
        test_single_bytes();
        test_back_to_back();
        test_abort();
        test_reset_mid_gap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
